// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, parity modes and line-level constants
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_t;

   localparam int PAR_NONE = 0;
   localparam int PAR_EVEN = 1;
   localparam int PAR_ODD  = 2;

   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;

   // Unknown parity modes fall back to "no parity bit".
   function automatic logic has_parity(input int mode);
      return (mode == PAR_EVEN) || (mode == PAR_ODD);
   endfunction

   // data_xor is the reduction XOR of the payload; odd parity inverts it.
   function automatic logic parity_bit(input logic data_xor, input int mode);
      return (mode == PAR_ODD) ? ~data_xor : data_xor;
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - bit-period counter with a terminal-count tick
module uart_baud_tick #(
   parameter int CLKS_PER_BIT = 5208
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   output logic tick
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] count;

   assign tick = (count == LAST);

   // Count 0..CLKS_PER_BIT-1, wrapping on the tick; clear holds it at zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear || tick) begin
         count <= '0;
      end else begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/uart_tx_framer.sv
// rtl/uart_tx_framer.sv - UART transmit framer: start, LSB-first data, optional parity, stop
module uart_tx_framer #(
   parameter int CLKS_PER_BIT = 5208,
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic                 txd,
   output logic                 tx_busy,
   output logic                 tx_done
);

   import uart_pkg::*;

   localparam int BW = $clog2(DATA_BITS + 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
   localparam logic USE_PAR = has_parity(PARITY);

   tx_state_t             state;
   logic [DATA_BITS-1:0]  shift;
   logic [BW-1:0]         bit_cnt;
   logic                  par_bit;
   logic                  tick;
   logic                  baud_clear;

   // Every non-idle state change lands on a tick, where the counter wraps to
   // zero by itself; holding it clear in IDLE makes the accept edge start at 0.
   assign baud_clear = (state == IDLE);
   assign tx_ready   = (state == IDLE);

   uart_baud_tick #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (baud_clear),
      .tick  (tick)
   );

   // Frame sequencer: owns state, shift register, bit counter and the registered line outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         txd     <= STOP_BIT;
         tx_busy <= 1'b0;
         tx_done <= 1'b0;
         bit_cnt <= '0;
         shift   <= '0;
         par_bit <= 1'b0;
      end else begin
         tx_done <= 1'b0;
         case (state)
            IDLE: begin
               txd <= STOP_BIT;
               if (tx_valid) begin
                  shift   <= tx_data;
                  par_bit <= parity_bit(^tx_data, PARITY);
                  bit_cnt <= '0;
                  state   <= START;
                  txd     <= START_BIT;
                  tx_busy <= 1'b1;
               end
            end
            START: begin
               if (tick) begin
                  state   <= DATA;
                  txd     <= shift[0];
                  bit_cnt <= '0;
               end
            end
            DATA: begin
               if (tick) begin
                  if (bit_cnt == LAST_BIT) begin
                     bit_cnt <= '0;
                     if (USE_PAR) begin
                        state <= uart_pkg::PARITY;
                        txd   <= par_bit;
                     end else begin
                        state <= STOP;
                        txd   <= STOP_BIT;
                     end
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                     shift   <= shift >> 1;
                     txd     <= shift[1];
                  end
               end
            end
            uart_pkg::PARITY: begin
               if (tick) begin
                  state <= STOP;
                  txd   <= STOP_BIT;
               end
            end
            STOP: begin
               if (tick) begin
                  state   <= IDLE;
                  txd     <= STOP_BIT;
                  tx_busy <= 1'b0;
                  tx_done <= 1'b1;
               end
            end
            default: begin
               state   <= IDLE;
               txd     <= STOP_BIT;
               tx_busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_framer.sv
// tb/tb_uart_tx_framer.sv - scoreboard bench for uart_tx_framer over four parameter sets
module tb_uart_tx_framer;

   localparam int NI = 4;

   typedef struct {
      logic [7:0] data;
      int         acc;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;
   bit fin [NI];

   task automatic chk(input bit ok, input string name, input int gi,
                      input logic [63:0] act, input logic [63:0] want);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s inst=%0d got=%0h want=%0h at cycle %0d", name, gi, act, want, cyc);
      end
   endtask

   function automatic int cfg_cpb(input int g);
      return (g == 3) ? 2 : 4;
   endfunction

   function automatic int cfg_par(input int g);
      return (g == 1) ? 1 : ((g == 2) ? 2 : 0);
   endfunction

   // Line level during frame bit k: start, 8 data LSB-first, optional parity, stop.
   function automatic logic model_bit(input logic [7:0] d, input int par, input int k);
      int ones;
      ones = $countones(d);
      if (k == 0) return 1'b0;
      if (k <= 8) return d[k-1];
      if (par != 0 && k == 9) return (par == 1) ? (ones % 2 == 1) : (ones % 2 == 0);
      return 1'b1;
   endfunction

   for (genvar g = 0; g < NI; g++) begin : inst
      localparam int CPB = cfg_cpb(g);
      localparam int PAR = cfg_par(g);
      localparam int L   = ((PAR == 0) ? 10 : 11) * CPB;

      logic       rst_n;
      logic [7:0] tx_data;
      logic       tx_valid;
      logic       tx_ready;
      logic       txd;
      logic       tx_busy;
      logic       tx_done;

      exp_t q[$];
      int   next_free   = 0;
      int   exp_frames  = 0;
      int   done_total  = 0;

      uart_tx_framer #(
         .CLKS_PER_BIT(CPB),
         .DATA_BITS   (8),
         .PARITY      (PAR)
      ) dut (
         .clk      (clk),
         .rst_n    (rst_n),
         .tx_data  (tx_data),
         .tx_valid (tx_valid),
         .tx_ready (tx_ready),
         .txd      (txd),
         .tx_busy  (tx_busy),
         .tx_done  (tx_done)
      );

      task automatic wait_free(input int gap);
         while (cyc + 1 < next_free + gap) begin
            @(posedge clk);
            #1;
         end
      endtask

      task automatic send(input logic [7:0] d, input int gap);
         wait_free(gap);
         tx_data  = d;
         tx_valid = 1'b1;
         q.push_back('{d, cyc + 1});
         next_free = cyc + 1 + L + 1;
         exp_frames++;
         @(posedge clk);
         #1;
         tx_valid = 1'b0;
         tx_data  = 8'($urandom);
         repeat (CPB + 1) @(posedge clk);
         #1;
         tx_valid = 1'b1;
         tx_data  = 8'($urandom);
         @(posedge clk);
         #1;
         tx_valid = 1'b0;
      endtask

      task automatic b2b(input logic [7:0] d0, input logic [7:0] d1);
         int a0;
         wait_free(0);
         tx_data  = d0;
         tx_valid = 1'b1;
         a0 = cyc + 1;
         q.push_back('{d0, a0});
         @(posedge clk);
         #1;
         tx_data = d1;
         q.push_back('{d1, a0 + L + 1});
         exp_frames += 2;
         while (cyc < a0 + L + 1) begin
            @(posedge clk);
            #1;
         end
         tx_valid  = 1'b0;
         next_free = a0 + 2 * (L + 1);
      endtask

      // Stimulus
      initial begin
         int bad;
         rst_n    = 1'b0;
         tx_valid = 1'b0;
         tx_data  = 8'h00;
         repeat (3) @(posedge clk);
         #1;
         chk({txd, tx_busy, tx_done, tx_ready} == 4'b1001, "reset_state", g,
             64'({txd, tx_busy, tx_done, tx_ready}), 64'h9);
         rst_n = 1'b1;
         bad = 0;
         repeat (100) begin
            @(negedge clk);
            if (txd !== 1'b1 || tx_ready !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) bad++;
         end
         chk(bad == 0, "idle_hold", g, 64'(bad), 64'd0);
         @(posedge clk);
         #1;
         next_free = cyc + 1;

         send((g == 3) ? 8'h3C : 8'hA5, 0);
         b2b(8'h00, 8'hFF);

         send(8'($urandom), 1);
         repeat (CPB) @(posedge clk);
         #3;
         rst_n = 1'b0;
         #1;
         chk({txd, tx_busy, tx_done, tx_ready} == 4'b1001, "abort_state", g,
             64'({txd, tx_busy, tx_done, tx_ready}), 64'h9);
         exp_frames--;
         @(posedge clk);
         @(posedge clk);
         #1;
         rst_n = 1'b1;
         next_free = cyc + 1;
         send(8'h5A, 2);

         for (int i = 0; i < 6; i++) send(8'($urandom), int'($urandom_range(0, 3)));

         while (cyc < next_free + 2) begin
            @(posedge clk);
            #1;
         end
         chk(q.size() == 0, "queue_empty", g, 64'(q.size()), 64'd0);
         chk(done_total == exp_frames, "done_count", g, 64'(done_total), 64'(exp_frames));
         fin[g] = 1'b1;
      end

      // Monitor
      initial begin
         bit          capturing;
         int          idx;
         bit          busy_ok;
         exp_t        cur;
         logic [63:0] act;
         logic [63:0] ev;
         capturing = 1'b0;
         idx       = 0;
         busy_ok   = 1'b1;
         act       = '0;
         forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
               capturing = 1'b0;
               continue;
            end
            if (tx_done) done_total++;
            if (capturing) begin
               if (idx < L) begin
                  act[idx] = txd;
                  busy_ok  = busy_ok & tx_busy;
                  idx++;
               end else begin
                  ev = '0;
                  for (int i = 0; i < L; i++) ev[i] = model_bit(cur.data, PAR, i / CPB);
                  chk(act == ev, "frame", g, act, ev);
                  chk(busy_ok, "busy_during_frame", g, 64'(busy_ok), 64'd1);
                  chk({tx_done, txd, tx_busy, tx_ready} == 4'b1101, "frame_end", g,
                      64'({tx_done, txd, tx_busy, tx_ready}), 64'hD);
                  capturing = 1'b0;
               end
            end else if (txd == 1'b0) begin
               if (q.size() == 0) begin
                  chk(1'b0, "unexpected_start", g, 64'(cyc), 64'd0);
               end else begin
                  cur = q.pop_front();
                  chk(cyc == cur.acc, "start_cycle", g, 64'(cyc), 64'(cur.acc));
                  capturing = 1'b1;
                  act       = '0;
                  idx       = 1;
                  busy_ok   = tx_busy;
               end
            end else if (q.size() > 0 && cyc > q[0].acc) begin
               chk(1'b0, "missing_start", g, 64'(cyc), 64'(q[0].acc));
               void'(q.pop_front());
            end
         end
      end
   end

   // Wait for every instance, bounded, then report
   initial begin
      bit all_done;
      all_done = 1'b0;
      for (int k = 0; k < 20000 && !all_done; k++) begin
         @(posedge clk);
         all_done = fin[0] & fin[1] & fin[2] & fin[3];
      end
      checks++;
      if (!all_done) begin
         errors++;
         $display("FAIL timeout got=not_finished want=finished at cycle %0d", cyc);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
